// File: rtl/coprocessor0_pkg.sv
// Coprocessor-0 register addresses, Status/Cause field layouts and reset
// constants shared by the CP0 register file and its timer.
package coprocessor_params;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef struct packed {
        logic [8:0] zero_31_23;
        logic       bev;
        logic [5:0] zero_21_16;
        logic [7:0] im;
        logic [5:0] zero_7_2;
        logic       exl;
        logic       ie;
    } status_t;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] zero_29_16;
        logic [7:0]  ip;
        logic        zero_7;
        logic [4:0]  exc_code;
        logic [1:0]  zero_1_0;
    } cause_t;

    localparam status_t STATUS_RESET = status_t'(32'h0040_0000);

endpackage

// File: rtl/wb_stage_params.sv
// Writeback-stage shared types. The CP0 bus carries MTC0 writes and
// exception/ERET commit information from WB into coprocessor 0.
package wb_stage_params;

    typedef struct packed {
        logic [4:0]  address_register;
        logic [2:0]  address_select;
        logic        write_enabled;
        logic [31:0] write_data;
        logic        exception_valid;
        logic [31:0] exception_address;
        logic        eret_flush;
        logic        in_delay_slot;
        logic [4:0]  exception_code;
        logic        is_address_fault;
        logic [31:0] badvaddr_value;
    } wb_to_cp0_bus_t;

endpackage

// File: rtl/coprocessor0_timer.sv
// Count/Compare timer: Count advances once per COUNT_DIVIDE clocks (1 or 2),
// TI latches one clock after Count == Compare and clears on Compare writes.
module cp0_timer #(
    parameter int COUNT_DIVIDE = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_count_write,
    input  logic        i_compare_write,
    input  logic        i_clear_timer_interrupt,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_timer_interrupt
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_phase;
    logic        r_timer_interrupt;
    logic        w_tick;

    assign w_tick = (COUNT_DIVIDE == 1) ? 1'b1 : r_phase;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count           <= 32'd0;
            r_compare         <= 32'd0;
            r_phase           <= 1'b0;
            r_timer_interrupt <= 1'b0;
        end else begin
            // A software Count write restarts the divide phase so the new value holds COUNT_DIVIDE clocks.
            if (i_count_write) begin
                r_count <= i_write_data;
                r_phase <= 1'b0;
            end else begin
                if (w_tick) begin
                    r_count <= r_count + 32'd1;
                end
                r_phase <= (COUNT_DIVIDE == 2) ? ~r_phase : 1'b0;
            end

            if (i_compare_write) begin
                r_compare <= i_write_data;
            end

            if (i_clear_timer_interrupt) begin
                r_timer_interrupt <= 1'b0;
            end else if (r_count == r_compare) begin
                r_timer_interrupt <= 1'b1;
            end
        end
    end

    assign o_count           = r_count;
    assign o_compare         = r_compare;
    assign o_timer_interrupt = r_timer_interrupt;

endmodule

// File: rtl/coprocessor0.sv
// Coprocessor-0 register file: MTC0 writes, exception/ERET commit, the
// Count/Compare timer and the interrupt-pending flag for the MIPS pipeline.
module coprocessor0
    import coprocessor_params::*;
#(
    parameter int COUNT_DIVIDE = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  wb_stage_params::wb_to_cp0_bus_t wb_to_cp0_bus,
    input  logic [5:0]                     hardware_interrupt,
    output logic [31:0]                    cp0_read_data,
    output logic [31:0]                    cp0_epc,
    output logic                           cp0_status_exl,
    output logic                           cp0_interrupt_pending
);

    logic [31:0] r_badvaddr;
    logic [31:0] r_epc;
    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;
    logic        r_cause_bd;
    logic [4:0]  r_cause_exc_code;
    logic [5:0]  r_cause_ip_hw;
    logic [1:0]  r_cause_ip_sw;

    logic        w_mtc0;
    logic        w_write_count;
    logic        w_write_compare;
    logic        w_write_status;
    logic        w_write_cause;
    logic        w_write_epc;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_timer_interrupt;
    status_t     w_status;
    cause_t      w_cause;

    // Exception and ERET both outrank software writes, so an MTC0 in the same cycle is dropped.
    assign w_mtc0 = wb_to_cp0_bus.write_enabled && !wb_to_cp0_bus.exception_valid
                    && !wb_to_cp0_bus.eret_flush && (wb_to_cp0_bus.address_select == 3'd0);

    assign w_write_count   = w_mtc0 && (wb_to_cp0_bus.address_register == CP0_COUNT);
    assign w_write_compare = w_mtc0 && (wb_to_cp0_bus.address_register == CP0_COMPARE);
    assign w_write_status  = w_mtc0 && (wb_to_cp0_bus.address_register == CP0_STATUS);
    assign w_write_cause   = w_mtc0 && (wb_to_cp0_bus.address_register == CP0_CAUSE);
    assign w_write_epc     = w_mtc0 && (wb_to_cp0_bus.address_register == CP0_EPC);

    cp0_timer #(
        .COUNT_DIVIDE(COUNT_DIVIDE)
    ) u_timer (
        .clock                   (clock),
        .reset                   (reset),
        .i_count_write           (w_write_count),
        .i_compare_write         (w_write_compare),
        .i_clear_timer_interrupt (w_write_compare),
        .i_write_data            (wb_to_cp0_bus.write_data),
        .o_count                 (w_count),
        .o_compare               (w_compare),
        .o_timer_interrupt       (w_timer_interrupt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_badvaddr       <= 32'd0;
            r_epc            <= 32'd0;
            r_status_im      <= STATUS_RESET.im;
            r_status_exl     <= STATUS_RESET.exl;
            r_status_ie      <= STATUS_RESET.ie;
            r_cause_bd       <= 1'b0;
            r_cause_exc_code <= 5'd0;
            r_cause_ip_hw    <= 6'd0;
            r_cause_ip_sw    <= 2'd0;
        end else begin
            r_cause_ip_hw <= {hardware_interrupt[5] | w_timer_interrupt, hardware_interrupt[4:0]};

            if (wb_to_cp0_bus.exception_valid) begin
                r_status_exl     <= 1'b1;
                r_cause_exc_code <= wb_to_cp0_bus.exception_code;
                // A nested exception keeps the original return point.
                if (!r_status_exl) begin
                    r_epc      <= wb_to_cp0_bus.in_delay_slot ? wb_to_cp0_bus.exception_address - 32'd4
                                                              : wb_to_cp0_bus.exception_address;
                    r_cause_bd <= wb_to_cp0_bus.in_delay_slot;
                end
                if (wb_to_cp0_bus.is_address_fault) begin
                    r_badvaddr <= wb_to_cp0_bus.badvaddr_value;
                end
            end else if (wb_to_cp0_bus.eret_flush) begin
                r_status_exl <= 1'b0;
            end

            if (w_write_status) begin
                r_status_im  <= wb_to_cp0_bus.write_data[15:8];
                r_status_exl <= wb_to_cp0_bus.write_data[1];
                r_status_ie  <= wb_to_cp0_bus.write_data[0];
            end
            if (w_write_cause) begin
                r_cause_ip_sw <= wb_to_cp0_bus.write_data[9:8];
            end
            if (w_write_epc) begin
                r_epc <= wb_to_cp0_bus.write_data;
            end
        end
    end

    always_comb begin
        w_status     = STATUS_RESET;
        w_status.im  = r_status_im;
        w_status.exl = r_status_exl;
        w_status.ie  = r_status_ie;

        w_cause          = '0;
        w_cause.bd       = r_cause_bd;
        w_cause.ti       = w_timer_interrupt;
        w_cause.ip       = {r_cause_ip_hw, r_cause_ip_sw};
        w_cause.exc_code = r_cause_exc_code;
    end

    always_comb begin
        cp0_read_data = 32'd0;
        if (wb_to_cp0_bus.address_select == 3'd0) begin
            case (wb_to_cp0_bus.address_register)
                CP0_BADVADDR: cp0_read_data = r_badvaddr;
                CP0_COUNT:    cp0_read_data = w_count;
                CP0_COMPARE:  cp0_read_data = w_compare;
                CP0_STATUS:   cp0_read_data = w_status;
                CP0_CAUSE:    cp0_read_data = w_cause;
                CP0_EPC:      cp0_read_data = r_epc;
                default:      cp0_read_data = 32'd0;
            endcase
        end
    end

    assign cp0_epc               = r_epc;
    assign cp0_status_exl        = r_status_exl;
    assign cp0_interrupt_pending = r_status_ie && !r_status_exl && |(w_cause.ip & r_status_im);

endmodule

// File: tb/tb_coprocessor0.sv
// Directed bench for coprocessor0: stimulus queues expected values, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_coprocessor0;
    import wb_stage_params::*;

    localparam int K_READ = 0;
    localparam int K_EPC  = 1;
    localparam int K_EXL  = 2;
    localparam int K_PEND = 3;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
        logic [31:0] mask;
    } chk_t;

    logic           clock = 1'b0;
    logic           reset;
    wb_to_cp0_bus_t bus;
    logic [5:0]     hw;
    logic [31:0]    cp0_read_data;
    logic [31:0]    cp0_epc;
    logic           cp0_status_exl;
    logic           cp0_interrupt_pending;

    chk_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    coprocessor0 #(.COUNT_DIVIDE(2)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .wb_to_cp0_bus         (bus),
        .hardware_interrupt    (hw),
        .cp0_read_data         (cp0_read_data),
        .cp0_epc               (cp0_epc),
        .cp0_status_exl        (cp0_status_exl),
        .cp0_interrupt_pending (cp0_interrupt_pending)
    );

    always @(negedge clock) begin
        chk_t        c;
        logic [31:0] act;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            case (c.kind)
                K_READ:  act = cp0_read_data;
                K_EPC:   act = cp0_epc;
                K_EXL:   act = {31'd0, cp0_status_exl};
                default: act = {31'd0, cp0_interrupt_pending};
            endcase
            n_tests++;
            if ((act & c.mask) !== (c.exp & c.mask)) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (mask %h)", c.name, act & c.mask, c.exp & c.mask, c.mask);
            end
        end
    end

    task automatic expect_val(input string name, input int kind, input logic [31:0] exp,
                              input logic [31:0] mask = 32'hFFFF_FFFF);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.exp  = exp;
        c.mask = mask;
        sb.push_back(c);
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp,
                      input logic [31:0] mask = 32'hFFFF_FFFF);
        bus.address_register = a;
        bus.address_select   = 3'd0;
        expect_val(name, K_READ, exp, mask);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.write_enabled    = 1'b1;
        bus.address_register = a;
        bus.address_select   = 3'd0;
        bus.write_data       = d;
    endtask

    task automatic exc(input logic [31:0] a, input logic ds, input logic [4:0] code,
                       input logic af, input logic [31:0] bv);
        bus.exception_valid   = 1'b1;
        bus.exception_address = a;
        bus.in_delay_slot     = ds;
        bus.exception_code    = code;
        bus.is_address_fault  = af;
        bus.badvaddr_value    = bv;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        bus.write_enabled   = 1'b0;
        bus.exception_valid = 1'b0;
        bus.eret_flush      = 1'b0;
        bus.address_select  = 3'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        bus   = '0;
        hw    = 6'd0;
        reset = 1'b1;
        do_reset();

        // reset values
        rd("rst_cause", 13, 32'h0);
        expect_val("rst_pend", K_PEND, 0);
        expect_val("rst_exl", K_EXL, 0);
        expect_val("rst_epc", K_EPC, 0);
        step();
        rd("rst_status", 12, 32'h0040_0000); step();
        rd("rst_epc_rd", 14, 32'h0);         step();
        rd("rst_badvaddr", 8, 32'h0);        step();

        // Count sequence 0,0,1,1,2 after reset
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rd("count_seq", 9, 32'(i / 2));
            step();
        end

        // Status writable fields, old value on same-cycle read
        mtc0(12, 32'hFFFF_FFFF);
        rd("status_old", 12, 32'h0040_0000);
        step();
        rd("status_wr", 12, 32'h0040_FF03);
        expect_val("pend_exl_set", K_PEND, 0);
        step();
        mtc0(12, 32'h0);
        step();
        expect_val("exl_cleared", K_EXL, 0);

        // exception in delay slot
        exc(32'hBFC0_0100, 1'b1, 5'd4, 1'b1, 32'h1234_5671);
        expect_val("epc_no_comb", K_EPC, 32'h0);
        step();
        expect_val("exc_epc", K_EPC, 32'hBFC0_00FC);
        expect_val("exc_exl", K_EXL, 1);
        rd("exc_cause", 13, 32'h8000_0010, 32'h8000_007C);
        step();
        rd("exc_badvaddr", 8, 32'h1234_5671); step();
        rd("exc_epc_rd", 14, 32'hBFC0_00FC);  step();

        // nested exception keeps EPC/BD
        exc(32'h8000_0000, 1'b0, 5'd5, 1'b0, 32'hFFFF_FFFF);
        step();
        expect_val("nest_epc", K_EPC, 32'hBFC0_00FC);
        rd("nest_cause", 13, 32'h8000_0014, 32'h8000_007C);
        step();
        rd("nest_badvaddr", 8, 32'h1234_5671); step();

        bus.eret_flush = 1'b1;
        step();
        expect_val("eret_exl", K_EXL, 0);
        expect_val("eret_epc", K_EPC, 32'hBFC0_00FC);
        step();

        // EPC write, nonzero select and read-only BadVAddr
        mtc0(14, 32'h1234_5678); step();
        rd("epc_wr", 14, 32'h1234_5678); step();
        mtc0(14, 32'h5555_5555);
        bus.address_select = 3'd1;
        step();
        rd("epc_sel1_ignored", 14, 32'h1234_5678); step();
        bus.address_register = 5'd14;
        bus.address_select   = 3'd1;
        expect_val("sel1_reads_zero", K_READ, 32'h0);
        step();
        mtc0(8, 32'h0); step();
        rd("badvaddr_ro", 8, 32'h1234_5671); step();

        // timer: Count=10, Compare=12
        mtc0(9, 32'd10);  step();
        mtc0(11, 32'd12); step();
        rd("ti_low1", 13, 32'h0, 32'h4000_0000); step();
        rd("ti_low2", 13, 32'h0, 32'h4000_0000); step();
        rd("ti_low3", 13, 32'h0, 32'h4000_0000); step();
        rd("count_12", 9, 32'd12);               step();
        rd("ti_rise", 13, 32'h4000_0000, 32'h4000_0000); step();
        mtc0(12, 32'h0040_8001); step();
        expect_val("timer_pend", K_PEND, 1);
        mtc0(11, 32'd100); step();
        rd("ti_clear", 13, 32'h0, 32'h4000_0000); step();
        expect_val("timer_pend_gone", K_PEND, 0);

        // hardware interrupt 2 with IM[12]
        mtc0(12, 32'h0040_1001); step();
        hw = 6'b000100;
        expect_val("hw_pend_before", K_PEND, 0);
        step();
        expect_val("hw_pend", K_PEND, 1);
        rd("hw_ip", 13, 32'h0000_1000, 32'h0000_FC00);
        step();
        mtc0(12, 32'h0040_1003);
        expect_val("hw_pend_same_cyc", K_PEND, 1);
        step();
        expect_val("hw_pend_exl", K_PEND, 0);
        hw = 6'd0;
        step();

        // exception beats same-cycle MTC0 to EPC
        mtc0(12, 32'h0); step();
        exc(32'h8000_0180, 1'b0, 5'd8, 1'b0, 32'h0);
        mtc0(14, 32'hDEAD_BEEF);
        step();
        expect_val("exc_over_mtc0", K_EPC, 32'h8000_0180);
        expect_val("exc_over_exl", K_EXL, 1);
        step();
        bus.eret_flush = 1'b1;
        step();

        // Count wrap, then reset mid-count
        mtc0(11, 32'd3);          step();
        mtc0(9, 32'hFFFF_FFFF);   step();
        rd("wrap_a", 9, 32'hFFFF_FFFF); step();
        rd("wrap_b", 9, 32'hFFFF_FFFF); step();
        rd("wrap_0", 9, 32'h0);
        for (int i = 0; i < 6; i++) step();
        rd("wrap_3", 9, 32'd3);  step();
        rd("wrap_ti", 13, 32'h4000_0000, 32'h4000_0000);
        do_reset();
        rd("rst_mid_cause", 13, 32'h0);
        expect_val("rst_mid_exl", K_EXL, 0);
        expect_val("rst_mid_epc", K_EPC, 32'h0);
        step();
        rd("rst_mid_count", 9, 32'h0);
        step();
        step();

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coprocessor0.md
# coprocessor0

Coprocessor-0 register file for the MIPS core: the receiving end of the writeback stage's CP0 bus. Applies MTC0 writes, records exception state (EPC, Cause, BadVAddr, Status.EXL) on exception commit, clears EXL on ERET, and runs the Count/Compare timer. It supplies MFC0 read data, the ERET return address and the interrupt-pending flag to the pipeline.

## Interface
Parameters:
- COUNT_DIVIDE, 2: Count increments once per COUNT_DIVIDE clocks; legal values are 1 or 2.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- wb_to_cp0_bus  in  wb_stage_params::wb_to_cp0_bus_t  fields: address_register[4:0], address_select[2:0], write_enabled, write_data[31:0], exception_valid, exception_address[31:0], eret_flush, in_delay_slot, exception_code[4:0], is_address_fault, badvaddr_value[31:0]
- hardware_interrupt  in  6  external interrupt lines, level-sensitive, sampled each clock
- cp0_read_data  out  32  combinational read of the register selected by address_register/address_select
- cp0_epc  out  32  current EPC, used as the ERET target
- cp0_status_exl  out  1  Status.EXL
- cp0_interrupt_pending  out  1  Status.IE & !Status.EXL & |(Cause.IP & Status.IM)

## Operation
Registers are select 0 only; any other select or address reads as 0 and ignores writes.
- BadVAddr (8): read-only to software. Loaded with badvaddr_value when an exception is committed with is_address_fault set.
- Count (9): read/write. Increments by one every COUNT_DIVIDE clocks and wraps at 0xFFFF_FFFF to 0.
- Compare (11): read/write. Any write clears Cause.TI.
- Status (12): BEV bit 22 reads 1 and cannot be written. IM[15:8], EXL[1] and IE[0] are writable. All other bits read 0.
- Cause (13): BD[31], TI[30], IP[15:10], IP[9:8] and ExcCode[6:2].
  - Only IP[9:8] is software-writable.
  - IP[15:10] = {hardware_interrupt[5] | TI, hardware_interrupt[4:0]}, registered each clock.
- EPC (14): read/write.

Event priority within one clock, highest first:
1. reset
2. exception_valid
3. eret_flush
4. write_enabled

Exception commit:
- EXL <= 1 and ExcCode <= exception_code.
- If EXL was 0 beforehand: EPC <= in_delay_slot ? exception_address-4 : exception_address, and BD <= in_delay_slot.
- If EXL was already 1, EPC and BD are unchanged.
- Any MTC0 in the same cycle is discarded.

ERET: EXL <= 0.

Timer:
- TI is set in the cycle after Count == Compare, evaluated on the registered values.
- A Compare write in the same cycle wins: TI is cleared.
- A Count write overrides the increment in that cycle and restarts the divide phase.

## Timing
- Reset values: BadVAddr 0, Count 0, Compare 0, Status 0x0040_0000, Cause 0, EPC 0, divide phase 0. After reset, cp0_read_data reflects the addressed register, cp0_interrupt_pending is 0 and cp0_status_exl is 0.
- Writes take effect at the clock edge; a same-cycle read returns the old value. This is the latency MFC0 in WB relies on.
- cp0_epc and cp0_status_exl are register outputs with no combinational path from the bus.
- cp0_interrupt_pending is combinational from registered state only.
- hardware_interrupt reaches Cause.IP after 1 clock and cp0_interrupt_pending after 1 clock.
- With COUNT_DIVIDE = 2, Count reads 0,0,1,1,2,… in successive cycles after reset.

## Structure
- coprocessor_params package holds:
  - address constants CP0_BADVADDR=8, CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14
  - packed typedefs status_t and cause_t with named fields
  - the Status reset constant
- wb_to_cp0_bus_t remains in wb_stage_params.
- One sub-module, cp0_timer, owns Count, Compare, the divide phase and TI. It exports count, compare and timer_interrupt, and takes write strobes for Count and Compare plus the Compare-write clear.

## Test plan
- Reset, then read addresses 12, 13 and 14: 0x0040_0000, 0, 0. Write 0xFFFF_FFFF to Status, then read: 0x0040_FF03.
- Exception with exception_address=0xBFC0_0100, in_delay_slot=1, code=4, is_address_fault=1, badvaddr=0x1234_5671: expect EPC=0xBFC0_00FC, Cause.BD=1, ExcCode=4, BadVAddr=0x1234_5671, EXL=1. Issue a second exception at 0x8000_0000: EPC is unchanged. ERET: EXL=0.
- Write Count=10 and Compare=12 with COUNT_DIVIDE=2: TI rises 5 clocks after the Count write. With Status=0x0040_8001, cp0_interrupt_pending=1. Write Compare: TI=0 on the next clock.
- Raise hardware_interrupt[2] with IM[12]=1, IE=1, EXL=0: pending=1 one clock later. Set EXL=1: pending=0.
- In the same cycle, assert exception_valid and an MTC0 to EPC with 0xDEAD_BEEF: EPC takes the exception value, not 0xDEAD_BEEF.
- Count=0xFFFF_FFFF wraps to 0 after COUNT_DIVIDE clocks. Assert reset mid-count: Count=0 and TI=0 on the next clock.
